// File: rtl/encoder_8to3.sv
// Registered 8-to-3 priority encoder (bit 7 wins) with valid flag.
// Optional multi-hot detection compiled in with `ENCODER8TO3_ERR_EN.
module encoder_8to3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       valid
`ifdef ENCODER8TO3_ERR_EN
  ,
  output logic       multi_hot
`endif
);

  logic [2:0] out_q, out_d;
  logic       valid_q, valid_d;

  // Ascending scan so the highest set bit is the last assignment and wins.
  always_comb begin
    out_d   = '0;
    valid_d = |in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (in[i]) out_d = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;

`ifdef ENCODER8TO3_ERR_EN
  logic multi_hot_q, multi_hot_d;

  // Clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    multi_hot_d = |(in & (in - 8'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) multi_hot_q <= 1'b0;
    else        multi_hot_q <= multi_hot_d;
  end

  assign multi_hot = multi_hot_q;
`endif

endmodule

// File: tb/tb_encoder_8to3.sv
// Self-checking bench for encoder_8to3; covers both builds of ENCODER8TO3_ERR_EN.
module tb_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_r = '0;
  logic [2:0] out_w;
  logic       valid_w;
  logic       mh_w;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

`ifdef ENCODER8TO3_ERR_EN
  encoder_8to3 dut (
    .clk(clk), .rst_n(rst_n), .in(in_r), .out(out_w), .valid(valid_w), .multi_hot(mh_w)
  );
`else
  encoder_8to3 dut (
    .clk(clk), .rst_n(rst_n), .in(in_r), .out(out_w), .valid(valid_w)
  );
  assign mh_w = 1'b0;
`endif

  // Reference: {index, valid, multi_hot}; index = floor(log2(v)).
  function automatic logic [4:0] model(input logic [7:0] v);
    int idx;
    logic mh;
    idx = (v == 8'd0) ? 0 : $clog2(int'(v) + 1) - 1;
`ifdef ENCODER8TO3_ERR_EN
    mh = ($countones(v) >= 2);
`else
    mh = 1'b0;
`endif
    return {idx[2:0], v != 8'd0, mh};
  endfunction

  function automatic logic [4:0] observed();
    return {out_w, valid_w, mh_w};
  endfunction

  task automatic test_reset();
    logic [4:0] got;
    rst_n = 1'b0;
    in_r  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = observed();
      checks++;
      if (got !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, got, 5'b0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    got = observed();
    checks++;
    if (got !== model(8'hFF)) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", got, model(8'hFF));
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] got;
    @(negedge clk); in_r = 8'hC0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    got = observed();
    checks++;
    if (got !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", got, 5'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_r  = 8'h24;
    @(posedge clk); #1;
    got = observed();
    checks++;
    if (got !== model(8'h24)) begin
      errors++;
      $display("FAIL post_reset_sample got=%h exp=%h", got, model(8'h24));
    end
  endtask

  task automatic test_onehot_sweep();
    logic [4:0] got;
    logic [7:0] v;
    for (int k = 0; k < 8; k++) begin
      v = 8'd1 << k;
      @(negedge clk); in_r = v;
      @(posedge clk); #1;
      got = observed();
      checks++;
      if (got !== model(v) || out_w !== 3'(k)) begin
        errors++;
        $display("FAIL onehot_%0d got=%h exp=%h", k, got, model(v));
      end
    end
  endtask

  task automatic test_zero();
    logic [4:0] got;
    @(negedge clk); in_r = 8'h00;
    @(posedge clk); #1;
    got = observed();
    checks++;
    if (got !== 5'b0) begin
      errors++;
      $display("FAIL zero_input got=%h exp=%h", got, 5'b0);
    end
  endtask

  task automatic test_priority();
    logic [4:0] got;
    logic [7:0] vecs [4] = '{8'b0010_0110, 8'hFF, 8'h03, 8'h81};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_r = vecs[i];
      @(posedge clk); #1;
      got = observed();
      checks++;
      if (got !== model(vecs[i])) begin
        errors++;
        $display("FAIL priority_%h got=%h exp=%h", vecs[i], got, model(vecs[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got;
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0) ? 8'h80 : 8'h01;
      @(negedge clk); in_r = v;
      @(posedge clk); #1;
      got = observed();
      checks++;
      if (got !== model(v)) begin
        errors++;
        $display("FAIL back_to_back_%0d got=%h exp=%h", i, got, model(v));
      end
    end
  endtask

  task automatic test_hold();
    logic [4:0] got;
    @(negedge clk); in_r = 8'h10;
    @(posedge clk); #1;
    in_r = 8'h02;
    #3;
    got = observed();
    checks++;
    if (got !== model(8'h10)) begin
      errors++;
      $display("FAIL hold_between_edges got=%h exp=%h", got, model(8'h10));
    end
  endtask

  task automatic test_random();
    logic [4:0] got;
    logic [7:0] v;
    for (int i = 0; i < 200; i++) begin
      v = 8'($urandom);
      @(negedge clk); in_r = v;
      @(posedge clk); #1;
      got = observed();
      checks++;
      if (got !== model(v)) begin
        errors++;
        $display("FAIL random_%0d in=%h got=%h exp=%h", i, v, got, model(v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_onehot_sweep();
    test_zero();
    test_priority();
    test_back_to_back();
    test_hold();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
